// File: rtl/sdram_arb_pkg.sv
// Shared constants and state type for the SDRAM client arbiter.
package sdram_arb_pkg;

  localparam int NUM_CLIENTS = 3;
  localparam int CL_PCM      = 0;
  localparam int CL_LINE     = 1;
  localparam int CL_BG       = 2;

  localparam int ADDR_W_DEF  = 25;
  localparam int DATA_W_DEF  = 16;
  localparam int LEN_W_DEF   = 4;
  localparam int BE_W        = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational burst winner select: PCM strict priority, line/bg round-robin.
// rr = 1 means the bg client was served last, so the line client is favoured.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] cl_req,
  input  logic                   rr,
  output logic [NUM_CLIENTS-1:0] winner,
  output logic                   valid
);

  always_comb begin
    winner = '0;
    if (cl_req[CL_PCM]) begin
      winner[CL_PCM] = 1'b1;
    end else if (cl_req[CL_LINE] && cl_req[CL_BG]) begin
      if (rr) winner[CL_LINE] = 1'b1;
      else    winner[CL_BG]   = 1'b1;
    end else if (cl_req[CL_LINE]) begin
      winner[CL_LINE] = 1'b1;
    end else if (cl_req[CL_BG]) begin
      winner[CL_BG] = 1'b1;
    end
  end

  assign valid = |cl_req;

endmodule

// File: rtl/sdram_client_arbiter.sv
// Grants whole SDRAM bursts to one of three clients; one IDLE cycle between bursts.
// Per-word ack, done and read data are combinational from the SDRAM side; hold blocks new grants only.
module sdram_client_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                hold,
  input  logic [NUM_CLIENTS-1:0]              cl_req,
  input  logic [NUM_CLIENTS-1:0]              cl_we,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  cl_addr,
  input  logic [NUM_CLIENTS-1:0][LEN_W-1:0]   cl_len,
  input  logic [NUM_CLIENTS-1:0][BE_W-1:0]    cl_be,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  cl_wrdata,
  output logic [NUM_CLIENTS-1:0]              cl_gnt,
  output logic [NUM_CLIENTS-1:0]              cl_ac,
  output logic [NUM_CLIENTS-1:0]              cl_done,
  output logic [DATA_W-1:0]                   cl_rddata,
  output logic [ADDR_W-1:0]                   ar_addr,
  output logic [BE_W-1:0]                     ar_be,
  output logic                                ar_read,
  output logic                                ar_write,
  output logic [DATA_W-1:0]                   ar_wrdata,
  input  logic                                ar_ac,
  input  logic [DATA_W-1:0]                   ar_rddata
);

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic [NUM_CLIENTS-1:0] owner;
  logic [NUM_CLIENTS-1:0] win;
  logic                   win_valid;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W-1:0]      sel_addr;
  logic [LEN_W-1:0]       cnt;
  logic [LEN_W-1:0]       sel_len;
  logic                   we;
  logic                   sel_we;
  logic [BE_W-1:0]        be;
  logic [BE_W-1:0]        sel_be;
  logic                   rr;
  logic                   xfer;
  logic                   grant;
  logic                   last_word;

  sdram_arb_pick u_pick (
    .cl_req (cl_req),
    .rr     (rr),
    .winner (win),
    .valid  (win_valid)
  );

  // Burst parameters of the winning client, captured on grant.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_we   = 1'b0;
    sel_be   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win[i]) begin
        sel_addr = cl_addr[i];
        sel_len  = cl_len[i];
        sel_we   = cl_we[i];
        sel_be   = cl_be[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: begin
        if (!hold && win_valid) begin
          grant     = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (ar_ac && (cnt == '0)) begin
          last_word = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= '0;
      addr  <= '0;
      cnt   <= '0;
      we    <= 1'b0;
      be    <= '0;
      rr    <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= win;
        addr  <= sel_addr;
        cnt   <= sel_len;
        we    <= sel_we;
        be    <= sel_be;
      end else if (xfer && ar_ac) begin
        addr <= addr + ADDR_W'(1);
        cnt  <= cnt - LEN_W'(1);
      end
      // PCM bursts leave the line/bg rotation untouched.
      if (last_word && !owner[CL_PCM]) begin
        rr <= owner[CL_BG];
      end
    end
  end

  assign xfer = (state == XFER);

  always_comb begin
    cl_gnt    = xfer ? owner : '0;
    cl_ac     = (xfer && ar_ac) ? owner : '0;
    cl_done   = last_word ? owner : '0;
    cl_rddata = ar_rddata;
    ar_read   = xfer && !we;
    ar_write  = xfer && we;
    ar_be     = xfer ? be : '0;
    ar_addr   = xfer ? addr : '0;
    ar_wrdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (xfer && owner[i]) ar_wrdata = cl_wrdata[i];
    end
  end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Scoreboard bench for sdram_client_arbiter: directed scenarios plus random traffic.
module tb_sdram_client_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int LW = 4;

  logic                clk       = 1'b0;
  logic                reset_n   = 1'b0;
  logic                hold      = 1'b0;
  logic [2:0]          cl_req    = '0;
  logic [2:0]          cl_we     = '0;
  logic [2:0][AW-1:0]  cl_addr   = '0;
  logic [2:0][LW-1:0]  cl_len    = '0;
  logic [2:0][1:0]     cl_be     = '0;
  logic [2:0][DW-1:0]  cl_wrdata = '0;
  logic [2:0]          cl_gnt;
  logic [2:0]          cl_ac;
  logic [2:0]          cl_done;
  logic [DW-1:0]       cl_rddata;
  logic [AW-1:0]       ar_addr;
  logic [1:0]          ar_be;
  logic                ar_read;
  logic                ar_write;
  logic [DW-1:0]       ar_wrdata;
  logic                ar_ac     = 1'b0;
  logic [DW-1:0]       ar_rddata = '0;

  sdram_client_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold      (hold),
    .cl_req    (cl_req),
    .cl_we     (cl_we),
    .cl_addr   (cl_addr),
    .cl_len    (cl_len),
    .cl_be     (cl_be),
    .cl_wrdata (cl_wrdata),
    .cl_gnt    (cl_gnt),
    .cl_ac     (cl_ac),
    .cl_done   (cl_done),
    .cl_rddata (cl_rddata),
    .ar_addr   (ar_addr),
    .ar_be     (ar_be),
    .ar_read   (ar_read),
    .ar_write  (ar_write),
    .ar_wrdata (ar_wrdata),
    .ar_ac     (ar_ac),
    .ar_rddata (ar_rddata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int max);
    n_checks++;
    if (n >= max) begin
      n_errors++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, max);
    end
  endtask

  function automatic logic [2:0] oh(input int i);
    oh = 3'b001 << i;
  endfunction

  // Reference model: burst-level arbitration from the priority/round-robin rules
  typedef struct {
    longint addr;
    int     owner;
    bit     last;
  } word_t;

  word_t    exp_q[$];
  int       grant_log[$];
  bit       m_busy  = 1'b0;
  int       m_owner = 0;
  int       m_left  = 0;
  int       m_last  = 2;
  logic     m_we    = 1'b0;
  logic [1:0] m_be  = '0;

  always @(negedge clk) begin : model
    int w;
    int len;
    if (!m_busy) begin
      chk("idle_gnt", cl_gnt, 0);
      chk("idle_strobes", {ar_read, ar_write}, 0);
      chk("idle_addr", ar_addr, 0);
      chk("idle_wrdata", ar_wrdata, 0);
    end else begin
      chk("gnt", cl_gnt, oh(m_owner));
      chk("rd_wr", {ar_read, ar_write}, m_we ? 64'd1 : 64'd2);
      chk("be", ar_be, m_be);
      chk("wrdata", ar_wrdata, cl_wrdata[m_owner]);
    end
    if (!reset_n) begin
      m_busy = 1'b0;
      m_last = 2;
      exp_q.delete();
    end else if (!m_busy) begin
      if (!hold && (cl_req != 3'b000)) begin
        if (cl_req[0])                   w = 0;
        else if (cl_req[1] && cl_req[2]) w = (m_last == 1) ? 2 : 1;
        else if (cl_req[1])              w = 1;
        else                             w = 2;
        len = int'(cl_len[w]);
        for (int k = 0; k <= len; k++) begin
          exp_q.push_back('{addr: (longint'(cl_addr[w]) + k) % (longint'(1) << AW),
                            owner: w, last: (k == len)});
        end
        m_busy  = 1'b1;
        m_owner = w;
        m_left  = len + 1;
        m_we    = cl_we[w];
        m_be    = cl_be[w];
        grant_log.push_back(w);
      end
    end else if (ar_ac) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        if (m_owner != 0) m_last = m_owner;
      end
    end
  end

  // Monitor: pops one expected word per acknowledged SDRAM access
  logic [2:0] last_done = '0;
  int         word_cnt  = 0;

  always @(negedge clk) begin : monitor
    word_t e;
    chk("rddata", cl_rddata, ar_rddata);
    last_done = cl_done;
    if (reset_n && (ar_read || ar_write) && ar_ac) begin
      word_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {ar_read, ar_write}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_addr", ar_addr, e.addr);
        chk("word_ac", cl_ac, oh(e.owner));
        chk("word_done", cl_done, e.last ? oh(e.owner) : 3'b000);
      end
    end else begin
      chk("no_ack", {cl_ac, cl_done}, 0);
    end
  end

  // Stimulus: client agents, SDRAM-side ack/data
  int         shots[3]   = '{0, 0, 0};
  int         req_pct[3] = '{0, 0, 0};
  bit         fix_en[3]  = '{0, 0, 0};
  logic [AW-1:0] fix_addr[3];
  logic [LW-1:0] fix_len[3];
  logic       fix_we[3];
  logic [1:0] fix_be[3];
  int         ac_pct    = 100;
  int         ac_period = 0;
  int         cyc       = 0;

  task automatic set_fixed(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic w, input logic [1:0] b);
    fix_en[i]   = 1'b1;
    fix_addr[i] = a;
    fix_len[i]  = l;
    fix_we[i]   = w;
    fix_be[i]   = b;
  endtask

  task automatic new_params(input int i);
    if (fix_en[i]) begin
      cl_addr[i] = fix_addr[i];
      cl_len[i]  = fix_len[i];
      cl_we[i]   = fix_we[i];
      cl_be[i]   = fix_be[i];
    end else begin
      cl_addr[i] = ($urandom_range(7) == 0) ? (25'h1FFFFFF - 25'($urandom_range(8)))
                                            : 25'($urandom);
      cl_len[i]  = 4'($urandom_range(15));
      cl_we[i]   = 1'($urandom_range(1));
      cl_be[i]   = 2'($urandom_range(3));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (last_done[i] && cl_req[i]) begin
        if (shots[i] > 0) begin
          shots[i]--;
          new_params(i);
        end else begin
          cl_req[i] = 1'b0;
        end
      end else if (!cl_req[i] && (shots[i] > 0 || $urandom_range(99) < req_pct[i])) begin
        if (shots[i] > 0) shots[i]--;
        new_params(i);
        cl_req[i] = 1'b1;
      end
      cl_wrdata[i] = 16'($urandom);
    end
    ar_rddata = 16'($urandom);
    ar_ac = reset_n && ((ac_period != 0) ? (cyc % ac_period == 0)
                                         : ($urandom_range(99) < ac_pct));
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((cl_req != 3'b000 || m_busy || (shots[0] + shots[1] + shots[2]) != 0) && n < max) begin
      step();
      n++;
    end
    bound_chk(name, n, max);
  endtask

  initial begin
    int base;
    int n;
    int wbase;

    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Single read burst from client 1
    set_fixed(1, 25'h00001F0, 4'd3, 1'b0, 2'b11);
    ac_pct = 100;
    base  = grant_log.size();
    wbase = word_cnt;
    shots[1] = 1;
    wait_idle("single_read_wait", 200);
    chk("single_read_grants", grant_log.size() - base, 1);
    chk("single_read_words", word_cnt - wbase, 4);
    fix_en[1] = 1'b0;

    // PCM beats bg when both request together
    base = grant_log.size();
    ac_pct = 70;
    shots[0] = 1;
    shots[2] = 1;
    wait_idle("priority_wait", 400);
    chk("priority_count", grant_log.size() - base, 2);
    chk("priority_first", grant_log[base], 0);
    chk("priority_second", grant_log[base + 1], 2);

    // Round-robin with continuous single-word requests
    set_fixed(1, 25'h0000100, 4'd0, 1'b0, 2'b01);
    set_fixed(2, 25'h0000200, 4'd0, 1'b1, 2'b10);
    ac_pct = 100;
    base = grant_log.size();
    shots[1] = 4;
    shots[2] = 4;
    wait_idle("rr_wait", 200);
    chk("rr_count", grant_log.size() - base, 8);
    if (grant_log.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) chk("rr_order", grant_log[base + k], (k % 2 == 0) ? 1 : 2);
    end
    fix_en[1] = 1'b0;
    fix_en[2] = 1'b0;

    // Hold blocks all grants, then release lets them through in priority order
    hold = 1'b1;
    base = grant_log.size();
    shots[0] = 1;
    shots[1] = 1;
    shots[2] = 1;
    repeat (20) step();
    chk("hold_no_grant", grant_log.size() - base, 0);
    hold = 1'b0;
    wait_idle("hold_release_wait", 400);
    chk("hold_release_count", grant_log.size() - base, 3);
    chk("hold_release_0", grant_log[base], 0);
    chk("hold_release_1", grant_log[base + 1], 1);
    chk("hold_release_2", grant_log[base + 2], 2);

    // Hold raised mid-burst: burst finishes, next request waits
    set_fixed(1, 25'h0123450, 4'd15, 1'b0, 2'b11);
    ac_pct = 100;
    base = grant_log.size();
    shots[1] = 1;
    n = 0;
    while (cl_gnt[1] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    bound_chk("midhold_grant_wait", n, 50);
    hold = 1'b1;
    shots[2] = 1;
    n = 0;
    while ((m_busy || cl_req[1]) && n < 100) begin
      step();
      n++;
    end
    bound_chk("midhold_finish_wait", n, 100);
    repeat (10) step();
    chk("midhold_blocked", grant_log.size() - base, 1);
    hold = 1'b0;
    wait_idle("midhold_release_wait", 200);
    chk("midhold_release", grant_log.size() - base, 2);
    fix_en[1] = 1'b0;

    // Write burst across the top of the address space with stalled acks
    set_fixed(2, 25'h1FFFFFE, 4'd2, 1'b1, 2'b10);
    ac_period = 3;
    wbase = word_cnt;
    shots[2] = 1;
    wait_idle("wrap_wait", 200);
    chk("wrap_words", word_cnt - wbase, 3);
    ac_period = 0;
    fix_en[2] = 1'b0;

    // Reset in the middle of an 8-word burst
    set_fixed(1, 25'h0004000, 4'd7, 1'b0, 2'b11);
    ac_pct = 100;
    base  = grant_log.size();
    wbase = word_cnt;
    shots[1] = 1;
    n = 0;
    while (word_cnt - wbase < 2 && n < 50) begin
      step();
      n++;
    end
    bound_chk("reset_mid_wait", n, 50);
    reset_n = 1'b0;
    ar_ac   = 1'b0;
    step();
    reset_n = 1'b1;
    wait_idle("reset_rearb_wait", 200);
    chk("reset_rearb_count", grant_log.size() - base, 2);
    chk("reset_rearb_owner", grant_log[base + 1], 1);
    fix_en[1] = 1'b0;

    // Random traffic
    req_pct = '{20, 30, 30};
    ac_pct  = 60;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) hold = ~hold;
      step();
    end
    req_pct = '{0, 0, 0};
    hold = 1'b0;
    wait_idle("drain_wait", 2000);
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (%0d checks, %0d errors)", n_checks, n_errors);
    $fatal(1);
  end

endmodule
